// File: rtl/stack_ctrl_if.sv
// Request/response and memory bus between the control unit, stack_ctrl and data RAM.
// The master side is the requester together with the RAM.
interface stack_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  push;
    logic                  pop;
    logic                  sp_load;
    logic [DATA_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] sp_in;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  overflow;
    logic                  underflow;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH-1:0] sp;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output push, pop, sp_load, push_data, sp_in, mem_rdata,
        input  busy, done, pop_data, overflow, underflow,
        input  empty, full, sp, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  push, pop, sp_load, push_data, sp_in, mem_rdata,
        output busy, done, pop_data, overflow, underflow,
        output empty, full, sp, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack pointer owner for the 8-bit CPU: sequences push/pop/sp_load onto a
// synchronous single-port RAM and flags overflow/underflow.
module stack_ctrl #(
    parameter int                    ADDR_WIDTH  = 9,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] STACK_TOP   = 9'h1FF,
    parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 9'h1F0
) (
    input  logic         clk,
    input  logic         reset,
    stack_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_WAIT} state_e;

    localparam logic [ADDR_WIDTH-1:0] FULL_SP = STACK_LIMIT - 1'b1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sp_q, sp_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  is_empty, is_full;

    assign is_empty = (sp_q == STACK_TOP);
    assign is_full  = (sp_q == FULL_SP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sp_q       <= STACK_TOP;
            wdata_q    <= '0;
            pop_data_q <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            wdata_q    <= wdata_d;
            pop_data_q <= pop_data_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Next state; rejected pushes/pops never leave IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.sp_load)
                    state_d = IDLE;
                else if (bus.push && !is_full)
                    state_d = PUSH_WR;
                else if (!bus.push && bus.pop && !is_empty)
                    state_d = POP_RD;
            end
            PUSH_WR:  state_d = IDLE;
            POP_RD:   state_d = POP_WAIT;
            POP_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        sp_d       = sp_q;
        wdata_d    = wdata_q;
        pop_data_d = pop_data_q;
        done_d     = 1'b0;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.sp_load) begin
                    sp_d   = bus.sp_in;
                    done_d = 1'b1;
                end else if (bus.push) begin
                    if (is_full) begin
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        wdata_d = bus.push_data;
                    end
                end else if (bus.pop && is_empty) begin
                    udf_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            PUSH_WR: begin
                sp_d   = sp_q - 1'b1;
                done_d = 1'b1;
            end
            POP_RD: sp_d = sp_q + 1'b1;
            POP_WAIT: begin
                pop_data_d = bus.mem_rdata;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory strobes decode straight from the registered state so reset kills them at once.
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.mem_we    = (state_q == PUSH_WR);
        bus.mem_re    = (state_q == POP_RD);
        bus.mem_addr  = (state_q == POP_RD) ? sp_q + 1'b1 : sp_q;
        bus.mem_wdata = wdata_q;
    end

    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.sp        = sp_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Hardware stack controller for the 8-bit CPU. It owns the stack pointer (SP) and sequences push, pop and SP-load requests from the control unit onto a synchronous single-port data memory. It also flags overflow and underflow. It sits between the instruction decoder (CALL/RET/PUSH/POP micro-ops) and the data RAM, and replaces a free-running up/down counter as the SP.

## Interface
Parameters:
- ADDR_WIDTH, 9: width of SP and memory address.
- DATA_WIDTH, 8: stack word width.
- STACK_TOP, 9'h1FF: highest stack address; SP value when empty.
- STACK_LIMIT, 9'h1F0: lowest usable stack address. Depth = STACK_TOP-STACK_LIMIT+1 (16 by default).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- push  in  1  push request; sampled only when busy=0.
- pop  in  1  pop request; sampled only when busy=0.
- sp_load  in  1  load SP from sp_in; sampled only when busy=0.
- push_data  in  DATA_WIDTH  word to push; sampled with push.
- sp_in  in  ADDR_WIDTH  new SP value for sp_load.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse when an operation completes, including rejected ones.
- pop_data  out  DATA_WIDTH  last popped word; held until the next successful pop.
- overflow  out  1  one-cycle pulse: push rejected because the stack is full.
- underflow  out  1  one-cycle pulse: pop rejected because the stack is empty.
- empty  out  1  SP == STACK_TOP.
- full  out  1  SP == STACK_LIMIT-1 (mod 2^ADDR_WIDTH).
- sp  out  ADDR_WIDTH  current SP; points to the next free location.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable. Read data is valid on mem_rdata one cycle after mem_re.
- mem_rdata  in  DATA_WIDTH  memory read data.

## Operation
- The stack grows downward. Push writes mem[SP] and then SP decrements. Pop increments SP and then reads mem[SP].
- FSM states: IDLE, PUSH_WR, POP_RD, POP_WAIT.
- Request priority in IDLE is sp_load > push > pop. Lower-priority requests in the same cycle are dropped, not queued.
- IDLE + sp_load:
  - SP <= sp_in; done pulses; state stays IDLE.
  - No range check is made; empty and full follow the new SP.
- IDLE + push:
  - If full: overflow=1 and done=1 next cycle; no memory access; SP unchanged; stay IDLE.
  - Otherwise: latch push_data, go to PUSH_WR.
- PUSH_WR:
  - mem_we=1, mem_addr=SP, mem_wdata=latched word.
  - Next edge: SP <= SP-1, done=1, go to IDLE.
- IDLE + pop:
  - If empty: underflow=1 and done=1 next cycle; SP unchanged; pop_data unchanged; stay IDLE.
  - Otherwise: go to POP_RD.
- POP_RD:
  - mem_re=1, mem_addr=SP+1.
  - Next edge: SP <= SP+1, go to POP_WAIT.
- POP_WAIT:
  - Next edge: pop_data <= mem_rdata, done=1, go to IDLE.
- Arithmetic is modulo 2^ADDR_WIDTH. SP±1 wraps and no carry is kept. full uses the wrapped STACK_LIMIT-1.
- mem_we, mem_re, mem_addr, mem_wdata and busy are decoded from the registered state and SP. In IDLE: mem_addr=SP, mem_we=0, mem_re=0.
- done, overflow, underflow and pop_data are registered.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, SP = STACK_TOP.
  - pop_data = 0; done, overflow, underflow, busy, mem_we, mem_re = 0.
  - empty = 1, full = 0.
- Request sampled at edge N (busy=0 in the cycle before N).
- Push latency:
  - mem_we high in cycle N..N+1.
  - SP and done update at edge N+1; done high N+1..N+2.
  - Next request can be sampled at edge N+2.
- Pop latency:
  - mem_re high N..N+1; SP updates at N+1.
  - pop_data and done valid from edge N+2.
  - Next request can be sampled at edge N+3.
- sp_load, overflow and underflow take effect at edge N; the flag or done pulse lasts one cycle.
- Requests while busy=1 are ignored. The requester must hold or reissue them.
- Reset asserted mid-operation aborts it:
  - mem_we and mem_re drop immediately.
  - No done pulse; pop_data cleared.

## Test plan
- Reset then 3 pushes (0xA1, 0xB2, 0xC3):
  - mem writes at 0x1FF, 0x1FE, 0x1FD.
  - sp = 0x1FC; each done arrives 2 cycles after its request.
- Then 3 pops:
  - pop_data = 0xC3, 0xB2, 0xA1, each 3 cycles after its request.
  - sp = 0x1FF, empty = 1.
- Pop when empty:
  - underflow and done pulse 1 cycle; no mem_re; sp stays 0x1FF; pop_data holds 0xA1.
- 16 pushes:
  - full = 1 at sp = 0x1EF.
  - A 17th push gives an overflow pulse, no mem_we, sp unchanged.
- Same cycle sp_load=1 (sp_in=0x120), push=1, pop=1:
  - sp = 0x120, done pulse, no memory access.
  - Then push=1, pop=1 together: push executes (write at 0x120, sp = 0x11F).
- Reset asserted during PUSH_WR:
  - mem_we drops immediately, sp = 0x1FF, no done pulse.
  - A push after reset release behaves normally.
